// File: rtl/cla_add64.sv
// ----------------------------------------------------------------------------
// cla_add64 -- registered 64-bit carry-lookahead adder
//
// Computes {cOut, s} = x + y + cIn (unsigned, 65-bit result) with a three
// level carry-lookahead tree:
//   level 0 : sixteen 4-bit CLA blocks (bit g/p, in-block carries, block G/P)
//   level 1 : four section lookahead units, each over 4 blocks
//   level 2 : one top lookahead unit over the 4 sections
// No carry ripples across block boundaries; every carry is produced by a
// lookahead equation from the level above.
//
// Ports (top):
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous, active-high reset; clears s and cOut
//   x     in  64   operand A
//   y     in  64   operand B
//   cIn   in   1   carry-in at bit 0
//   s     out 64   registered sum
//   cOut  out  1   registered carry-out of bit 63
//
// Interface timing: there is no handshake. A new operand set is sampled at
// every rising edge and its result is presented from that edge until the
// next one (latency of exactly one cycle, no stalls, no bubbles).
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// cla_lu4 -- 4-way lookahead unit
//   i_g/i_p : generate/propagate of four lower-level groups (index 0 = LSB)
//   i_c0    : carry into group 0
//   o_c     : carry into each group (o_c[0] is i_c0 passed through)
//   o_g/o_p : combined generate/propagate of the four groups
// Shared by the in-block carries, the section level and the top level.
// ----------------------------------------------------------------------------
module cla_lu4 (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_c0,
    output logic [3:0] o_c,
    output logic       o_g,
    output logic       o_p
);

    assign o_c[0] = i_c0;
    assign o_c[1] = i_g[0]
                  | (i_p[0] & i_c0);
    assign o_c[2] = i_g[1]
                  | (i_p[1] & i_g[0])
                  | (i_p[1] & i_p[0] & i_c0);
    assign o_c[3] = i_g[2]
                  | (i_p[2] & i_g[1])
                  | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c0);

    // Group G/P never depend on the incoming carry, so the tree has no
    // combinational loop even though carries flow back down from the top.
    assign o_g = i_g[3]
               | (i_p[3] & i_g[2])
               | (i_p[3] & i_p[2] & i_g[1])
               | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_p = &i_p;

endmodule

// ----------------------------------------------------------------------------
// cla4_block -- 4-bit CLA slice
//   i_x/i_y : operand bits of this slice
//   i_c0    : carry into bit 0 of the slice (from the section unit)
//   o_s     : sum bits
//   o_g/o_p : block generate/propagate for the section unit
// ----------------------------------------------------------------------------
module cla4_block (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_c0,
    output logic [3:0] o_s,
    output logic       o_g,
    output logic       o_p
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    cla_lu4 u_lu (
        .i_g  (w_g),
        .i_p  (w_p),
        .i_c0 (i_c0),
        .o_c  (w_c),
        .o_g  (o_g),
        .o_p  (o_p)
    );

    assign o_s = w_p ^ w_c;

endmodule

// ----------------------------------------------------------------------------
// cla64_comb -- purely combinational 64-bit lookahead adder
//   i_x/i_y : operands
//   i_cin   : carry-in
//   o_s     : sum
//   o_cout  : carry-out of bit 63
// ----------------------------------------------------------------------------
module cla64_comb (
    input  logic [63:0] i_x,
    input  logic [63:0] i_y,
    input  logic        i_cin,
    output logic [63:0] o_s,
    output logic        o_cout
);

    logic [15:0] w_blk_g;
    logic [15:0] w_blk_p;
    logic [15:0] w_blk_c;   // carry into each 4-bit block
    logic [3:0]  w_sec_g;
    logic [3:0]  w_sec_p;
    logic [3:0]  w_sec_c;   // carry into each 16-bit section
    logic        w_top_g;
    logic        w_top_p;

    // Level 0: sixteen 4-bit slices
    for (genvar b = 0; b < 16; b++) begin : g_blk
        cla4_block u_blk (
            .i_x  (i_x[4*b +: 4]),
            .i_y  (i_y[4*b +: 4]),
            .i_c0 (w_blk_c[b]),
            .o_s  (o_s[4*b +: 4]),
            .o_g  (w_blk_g[b]),
            .o_p  (w_blk_p[b])
        );
    end

    // Level 1: one lookahead unit per 16-bit section
    for (genvar k = 0; k < 4; k++) begin : g_sec
        cla_lu4 u_sec (
            .i_g  (w_blk_g[4*k +: 4]),
            .i_p  (w_blk_p[4*k +: 4]),
            .i_c0 (w_sec_c[k]),
            .o_c  (w_blk_c[4*k +: 4]),
            .o_g  (w_sec_g[k]),
            .o_p  (w_sec_p[k])
        );
    end

    // Level 2: top lookahead over the four sections
    cla_lu4 u_top (
        .i_g  (w_sec_g),
        .i_p  (w_sec_p),
        .i_c0 (i_cin),
        .o_c  (w_sec_c),
        .o_g  (w_top_g),
        .o_p  (w_top_p)
    );

    assign o_cout = w_top_g | (w_top_p & i_cin);

endmodule

// ----------------------------------------------------------------------------
// cla_add64 -- top: combinational CLA followed by the output register
// ----------------------------------------------------------------------------
module cla_add64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        cIn,
    output logic [63:0] s,
    output logic        cOut
);

    logic [63:0] w_sum;
    logic        w_cout;
    logic [63:0] r_s;
    logic        r_cout;

    cla64_comb u_add (
        .i_x    (x),
        .i_y    (y),
        .i_cin  (cIn),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    // Reloaded every edge, so each result depends only on that edge's inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= 64'h0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign s    = r_s;
    assign cOut = r_cout;

endmodule

// File: tb/tb_cla_add64.sv
// ----------------------------------------------------------------------------
// tb_cla_add64 -- self-checking bench for cla_add64
//
// The driver changes inputs on the falling edge and pushes the expected
// {cOut, s} into exp_q. The monitor notes at each rising edge whether a
// vector was being presented (and rst was low), then at the following
// falling edge pops the expected value and compares it with the outputs.
// Results flushed by an asynchronous reset are popped and discarded.
// ----------------------------------------------------------------------------
module tb_cla_add64;

  logic        clk;
  logic        rst;
  logic [63:0] x;
  logic [63:0] y;
  logic        cIn;
  logic [63:0] s;
  logic        cOut;

  logic        tb_vld;
  logic [64:0] exp_q[$];
  int          total;
  int          bad;

  cla_add64 dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .cIn  (cIn),
    .s    (s),
    .cOut (cOut)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {cOut,s}=%h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic [64:0] exp);
    @(negedge clk);
    x      = a;
    y      = b;
    cIn    = c;
    tb_vld = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic idle();
    @(negedge clk);
    tb_vld = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic        took;
    logic [64:0] e;
    forever begin
      @(posedge clk);
      took = tb_vld & ~rst;
      @(negedge clk);
      if (took) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", {cOut, s}, 65'h1_DEAD_BEEF_DEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          if (!rst) check("result", {cOut, s}, e);
        end
      end
    end
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    total  = 0;
    bad    = 0;
    tb_vld = 1'b0;
    rst    = 1'b0;
    x      = 64'h0;
    y      = 64'h0;
    cIn    = 1'b0;

    // 1: reset applies without a clock edge, holds while inputs are live
    #2 rst = 1'b1;
    #1 check("reset_async_no_clk", {cOut, s}, 65'h0);
    @(negedge clk);
    x   = 64'hFFFF_FFFF_FFFF_FFFE;
    y   = 64'h1;
    cIn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {cOut, s}, 65'h0);
    end
    @(negedge clk);
    rst    = 1'b0;
    tb_vld = 1'b1;
    exp_q.push_back({1'b1, 64'h0});

    // 2
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'h1,  1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    issue(64'hFFFF_FFFF_FFFF_FFEE, 64'h11, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    // 3: back to back
    issue(64'hE, 64'h11, 1'b0, {1'b0, 64'h1F});
    issue(64'hF, 64'h11, 1'b0, {1'b0, 64'h20});
    // 4: full-length propagate and top-bit carry
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {1'b1, 64'h0});
    // boundaries
    issue(64'h0, 64'h0, 1'b0, {1'b0, 64'h0});
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    // alternating patterns
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, {1'b1, 64'h0});
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, {1'b1, 64'h5555_5555_5555_5554});
    issue(64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1, {1'b0, 64'hAAAA_AAAA_AAAA_AAAB});
    // block / section carry boundaries at 3/4, 15/16, 31/32
    issue(64'hF, 64'h1, 1'b0, {1'b0, 64'h10});
    issue(64'hFFFF, 64'h1, 1'b0, {1'b0, 64'h1_0000});
    issue(64'hFFFF, 64'h0, 1'b1, {1'b0, 64'h1_0000});
    issue(64'hFFFF_FFFF, 64'h1, 1'b0, {1'b0, 64'h1_0000_0000});
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {1'b0, 64'h8000_0000_0000_0000});
    issue(64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_0000_0001, 1'b0, {1'b0, 64'h0001_0000_0000_0000});

    // 5: mid-stream asynchronous reset while a nonzero result is held
    issue(64'h1234, 64'h1111, 1'b0, {1'b0, 64'h2345});
    idle();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_midstream", {cOut, s}, 65'h0);
    issue(64'h5, 64'h6, 1'b0, {1'b0, 64'hB});
    tb_vld = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("reset_midstream_hold", {cOut, s}, 65'h0);
    rst = 1'b0;
    tb_vld = 1'b1;
    x   = 64'h5;
    y   = 64'h6;
    exp_q.push_back({1'b0, 64'hB});

    // 6: random operands against a 65-bit reference sum
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {64'h0, rc});
    end

    idle();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_add64.md
Name: cla_add64

Overview:
64-bit two's-complement/unsigned adder with carry-in and carry-out, built as a hierarchical carry-lookahead adder (CLA). Operands and carry-in are sampled at the clock edge, and the sum and carry-out are presented from output registers. It serves as the datapath adder for ALU-level blocks that need a fast, registered 64-bit add.

Parameters:
None. Width is fixed at 64 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
x  input  64  operand A
y  input  64  operand B
cIn  input  1  carry-in, added at bit 0
s  output  64  registered sum, (x + y + cIn) mod 2^64
cOut  output  1  registered carry-out of bit 63

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst is high: s = 64'h0 and cOut = 0, immediately, with no clock required.
  - Release of rst takes effect at the next rising clk edge.
- Function: {cOut, s} = x + y + cIn, an unsigned 65-bit result.
  - No overflow flag is produced; signed overflow is the caller's concern.
- Latency: exactly 1 cycle.
  - Inputs are sampled at rising edge N; the result is visible on s/cOut after edge N, until edge N+1.
  - A new operand set is accepted every cycle, with no handshake and no stall.
  - The outputs are registered at every edge, so each edge's result reflects only that edge's inputs.
- Carry structure (mandatory; no ripple chain across the full 64 bits):
  - Bit level: g_i = x_i & y_i and p_i = x_i ^ y_i.
  - 4-bit CLA blocks (16 blocks) produce group G/P and internal carries from lookahead equations.
  - Second-level lookahead unit over 4 blocks (4 units) produces section G/P and block carry-ins.
  - Top-level lookahead unit over the 4 sections produces section carry-ins and cOut = G_top | (P_top & cIn).
  - Sum bit: s_i = p_i ^ c_i.
  - The combinational adder and the output register stage may be split into submodules.
- Boundary conditions:
  - All-ones + 0 with cIn = 0 gives all-ones and cOut = 0.
  - All-ones + 0 with cIn = 1 gives 0 and cOut = 1. This is the full-length propagate case: the carry must traverse all 64 bits in the same cycle.
  - 0 + 0 + 0 gives 0, cOut = 0.
  - If rst is asserted mid-stream, the outputs clear asynchronously. The first result after rst is released is the one sampled at the first edge with rst low.
- Unknown (X) inputs are not specified; the bench drives only known values.

Test Plan:
1. rst high, x = FFFFFFFFFFFFFFFE, y = 1, cIn = 1, clocks running -> s = 0, cOut = 0 throughout reset. Deassert rst; after the next edge -> s = 0, cOut = 1.
2. x = FFFFFFFFFFFFFFFE, y = 0000000000000001, cIn = 0 -> one edge later s = FFFFFFFFFFFFFFFF, cOut = 0. Then x = FFFFFFFFFFFFFFEE, y = 0000000000000011, cIn = 0 -> s = FFFFFFFFFFFFFFFF, cOut = 0.
3. Back-to-back cycles with cIn = 0:
   - x = E, y = 11 -> s = 000000000000001F, cOut = 0.
   - x = F, y = 11 -> s = 0000000000000020, cOut = 0.
   - Each result appears one cycle after its operands, with no bubbles.
4. x = FFFFFFFFFFFFFFFF, y = 0, cIn = 1 -> s = 0, cOut = 1 (full 64-bit propagate). Then x = 8000000000000000, y = 8000000000000000, cIn = 0 -> s = 0, cOut = 1.
5. Assert rst asynchronously between edges while s holds a nonzero result -> s and cOut go to 0 before the next edge.
6. Randomized: at least 10,000 random x, y, cIn -> registered {cOut, s} equals the 65-bit reference sum one cycle later. Include directed patterns: alternating AAAA…/5555…, and per-block carry-boundary values at bits 3/4, 15/16, and 31/32.
